// File: rtl/sort_pkg.sv
// Shared types and helpers for the in-place insertion-sort engine.
package sort_pkg;

    // Engine control states
    typedef enum logic [3:0] {
        IDLE,
        RD_KEY_A,
        RD_KEY_D,
        RD_CMP_A,
        RD_CMP_D,
        WR_SHIFT,
        WR_KEY,
        NEXT_I,
        FINISH,
        ERR
    } sort_state_t;

    // Memory response code for a successful read
    localparam int RESP_OKAY = 0;

    // Widest element the comparator supports; narrower elements are zero-extended
    localparam int CMP_WDTH = 64;

    // True when key must move ahead of cmp. Signed ordering is obtained by
    // flipping the element's sign bit and then comparing unsigned. Equal
    // values never report out of order, which keeps the sort stable.
    function automatic logic out_of_order(
        input logic [CMP_WDTH-1:0] key,
        input logic [CMP_WDTH-1:0] cmp,
        input logic                desc,
        input logic                signed_cmp,
        input int unsigned         width
    );
        logic [CMP_WDTH-1:0] flip;
        logic [CMP_WDTH-1:0] k;
        logic [CMP_WDTH-1:0] c;
        flip = signed_cmp ? (CMP_WDTH'(1) << (width - 1)) : '0;
        k    = key ^ flip;
        c    = cmp ^ flip;
        return desc ? (k > c) : (k < c);
    endfunction

endpackage

// File: rtl/sort_wr_handshake.sv
// Tracks independent acceptance of the write-address and write-data beats.
// Both valids raise together when a write starts; each drops after its own
// handshake, and both_done marks the cycle in which the second one lands.
module sort_wr_handshake (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_aw_ready,
    input  logic i_w_ready,
    output logic o_aw_valid,
    output logic o_w_valid,
    output logic o_both_done
);

    logic r_aw_done;
    logic r_w_done;
    logic w_aw_fire;
    logic w_w_fire;

    assign o_aw_valid  = i_active & ~r_aw_done;
    assign o_w_valid   = i_active & ~r_w_done;
    assign w_aw_fire   = o_aw_valid & i_aw_ready;
    assign w_w_fire    = o_w_valid & i_w_ready;
    assign o_both_done = i_active & (r_aw_done | w_aw_fire) & (r_w_done | w_w_fire);

    // Remember which beat already completed; clear once the write finishes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (!i_active || o_both_done) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_aw_done <= r_aw_done | w_aw_fire;
            r_w_done  <= r_w_done | w_w_fire;
        end
    end

endmodule

// File: rtl/sort_engine.sv
// In-place insertion sort over an external memory reached through an
// AR/R/AW/W valid/ready port. Optional feature macro: SORT_PERF_CNT_EN adds a
// 16-bit saturating count of completed reads and writes (perf_count).
module sort_engine
    import sort_pkg::*;
#(
    parameter int ADDR_WDTH  = 4,
    parameter int DATA_WDTH  = 32,
    parameter int RESP_WDTH  = 1,
    parameter int SIGNED_CMP = 0
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_WDTH-1:0] base_addr,
    input  logic [ADDR_WDTH-1:0] arr_size,
    input  logic                 descending,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
`ifdef SORT_PERF_CNT_EN
    output logic [15:0]          perf_count,
`endif
    output logic                 ar_valid,
    input  logic                 ar_ready,
    output logic [ADDR_WDTH-1:0] ar_address,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [RESP_WDTH-1:0] r_resp,
    input  logic [DATA_WDTH-1:0] r_data,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic [ADDR_WDTH-1:0] aw_address,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [DATA_WDTH-1:0] w_data
);

    // Index width: one extra bit so j can hold -1 in two's complement
    localparam int IW = ADDR_WDTH + 1;

    sort_state_t          r_state;
    logic [ADDR_WDTH-1:0] r_base;
    logic [ADDR_WDTH-1:0] r_size;
    logic                 r_desc;
    logic [ADDR_WDTH-1:0] r_i;
    logic [IW-1:0]        r_j;
    logic [DATA_WDTH-1:0] r_key;
    logic [DATA_WDTH-1:0] r_cmp;

    sort_state_t          w_state_nxt;
    logic [ADDR_WDTH-1:0] w_base_nxt;
    logic [ADDR_WDTH-1:0] w_size_nxt;
    logic                 w_desc_nxt;
    logic [ADDR_WDTH-1:0] w_i_nxt;
    logic [IW-1:0]        w_j_nxt;
    logic [DATA_WDTH-1:0] w_key_nxt;
    logic [DATA_WDTH-1:0] w_cmp_nxt;

    logic          w_start_ok;
    logic          w_wr_active;
    logic          w_both_done;
    logic          w_r_fire;
    logic          w_resp_bad;
    logic          w_ooo;
    logic [IW-1:0] w_i_ext;
    logic [IW-1:0] w_i_plus1;

    assign w_start_ok = start && (r_state == IDLE || r_state == FINISH || r_state == ERR);
    assign w_r_fire   = r_valid & r_ready;
    assign w_resp_bad = (r_resp != RESP_WDTH'(RESP_OKAY));
    assign w_i_ext    = {1'b0, r_i};
    assign w_i_plus1  = w_i_ext + IW'(1);
    assign w_ooo      = out_of_order(CMP_WDTH'(r_key), CMP_WDTH'(r_data), r_desc,
                                     SIGNED_CMP != 0, DATA_WDTH);

    sort_wr_handshake u_wr_hs (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_active    (w_wr_active),
        .i_aw_ready  (aw_ready),
        .i_w_ready   (w_ready),
        .o_aw_valid  (aw_valid),
        .o_w_valid   (w_valid),
        .o_both_done (w_both_done)
    );

    // Next-state, datapath-next and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_size_nxt  = r_size;
        w_desc_nxt  = r_desc;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_key_nxt   = r_key;
        w_cmp_nxt   = r_cmp;
        ar_valid    = 1'b0;
        ar_address  = '0;
        r_ready     = 1'b0;
        aw_address  = '0;
        w_data      = '0;
        w_wr_active = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        error       = 1'b0;

        case (r_state)
            IDLE: begin
                busy = 1'b0;
            end
            RD_KEY_A: begin
                ar_valid   = 1'b1;
                ar_address = r_base + r_i;
                if (ar_ready) w_state_nxt = RD_KEY_D;
            end
            RD_KEY_D: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    if (w_resp_bad) begin
                        w_state_nxt = ERR;
                    end else begin
                        w_key_nxt   = r_data;
                        w_j_nxt     = w_i_ext - IW'(1);
                        w_state_nxt = RD_CMP_A;
                    end
                end
            end
            RD_CMP_A: begin
                ar_valid   = 1'b1;
                ar_address = r_base + r_j[ADDR_WDTH-1:0];
                if (ar_ready) w_state_nxt = RD_CMP_D;
            end
            RD_CMP_D: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    if (w_resp_bad) begin
                        w_state_nxt = ERR;
                    end else begin
                        w_cmp_nxt = r_data;
                        if (w_ooo)
                            w_state_nxt = WR_SHIFT;
                        else if (r_j == w_i_ext - IW'(1))
                            w_state_nxt = NEXT_I;   // key already in place
                        else
                            w_state_nxt = WR_KEY;
                    end
                end
            end
            WR_SHIFT: begin
                w_wr_active = 1'b1;
                aw_address  = r_base + r_j[ADDR_WDTH-1:0] + ADDR_WDTH'(1);
                w_data      = r_cmp;
                if (w_both_done) begin
                    w_j_nxt     = r_j - IW'(1);
                    w_state_nxt = (r_j == '0) ? WR_KEY : RD_CMP_A;
                end
            end
            WR_KEY: begin
                w_wr_active = 1'b1;
                aw_address  = r_base + r_j[ADDR_WDTH-1:0] + ADDR_WDTH'(1);
                w_data      = r_key;
                if (w_both_done) w_state_nxt = NEXT_I;
            end
            NEXT_I: begin
                w_i_nxt     = w_i_plus1[ADDR_WDTH-1:0];
                w_state_nxt = (w_i_plus1 < {1'b0, r_size}) ? RD_KEY_A : FINISH;
            end
            FINISH: begin
                busy        = 1'b0;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            ERR: begin
                busy  = 1'b0;
                error = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_start_ok) begin
            w_base_nxt  = base_addr;
            w_size_nxt  = arr_size;
            w_desc_nxt  = descending;
            w_i_nxt     = ADDR_WDTH'(1);
            w_j_nxt     = '0;
            w_state_nxt = (arr_size <= ADDR_WDTH'(1)) ? FINISH : RD_KEY_A;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_size  <= '0;
            r_desc  <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_key   <= '0;
            r_cmp   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
            r_size  <= w_size_nxt;
            r_desc  <= w_desc_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_key   <= w_key_nxt;
            r_cmp   <= w_cmp_nxt;
        end
    end

`ifdef SORT_PERF_CNT_EN
    logic [15:0] r_perf;

    // Count completed reads and writes, saturating; cleared when a sort starts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf <= '0;
        end else if (w_start_ok) begin
            r_perf <= '0;
        end else if ((w_r_fire || w_both_done) && r_perf != 16'hFFFF) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign perf_count = r_perf;
`endif

endmodule

// File: tb/tb_sort_engine.sv
// Self-checking bench for sort_engine: a randomly stalling memory model,
// a table of directed sort vectors, and hand-written corner sequences
// (read error, start while busy, reset with a half-accepted write).
module tb_sort_engine;
    import sort_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NV = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] arr_size = '0;
    logic          descending = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, error;
    logic          ar_valid, ar_ready;
    logic [AW-1:0] ar_address;
    logic          r_valid, r_ready;
    logic [0:0]    r_resp;
    logic [DW-1:0] r_data;
    logic          aw_valid, aw_ready;
    logic [AW-1:0] aw_address;
    logic          w_valid, w_ready;
    logic [DW-1:0] w_data;

    sort_engine #(
        .ADDR_WDTH (AW),
        .DATA_WDTH (DW),
        .RESP_WDTH (1),
        .SIGNED_CMP(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .base_addr  (base_addr),
        .arr_size   (arr_size),
        .descending (descending),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_address (ar_address),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_resp     (r_resp),
        .r_data     (r_data),
        .aw_valid   (aw_valid),
        .aw_ready   (aw_ready),
        .aw_address (aw_address),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int               base;
        int               size;
        bit               desc;
        logic [15:0][31:0] data;
        logic [15:0][31:0] expv;
        int               exp_rd;
        int               exp_wr;
    } vec_t;

    vec_t          vecs [NV];
    logic [DW-1:0] mem [16];
    logic [AW-1:0] aw_q [$];
    logic [DW-1:0] w_q [$];
    logic [AW-1:0] rd_addr;
    int            rd_count = 0;
    int            wr_count = 0;
    int            done_total = 0;
    int            err_target = -1;
    bit            w_hold = 1'b0;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0][31:0] pk8(input int a0, input int a1, input int a2, input int a3,
                                             input int a4, input int a5, input int a6, input int a7);
        logic [15:0][31:0] v;
        v = '0;
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
        return v;
    endfunction

    // Read slave: random address and data delays, one read at a time
    initial begin
        ar_ready = 1'b0; r_valid = 1'b0; r_resp = '0; r_data = '0;
        forever begin
            @(negedge clk);
            if (ar_valid) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (ar_valid) begin
                    rd_addr  = ar_address;
                    ar_ready = 1'b1;
                    rd_count++;
                    @(negedge clk);
                    ar_ready = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    r_data  = mem[rd_addr];
                    r_resp  = (rd_count == err_target) ? 1'b1 : 1'b0;
                    r_valid = 1'b1;
                    for (int k = 0; k < 50 && !r_ready; k++) @(negedge clk);
                    @(negedge clk);
                    r_valid = 1'b0;
                    r_resp  = '0;
                end
            end
        end
    end

    // Write-address slave
    initial begin
        aw_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (aw_valid) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (aw_valid) begin
                    aw_q.push_back(aw_address);
                    aw_ready = 1'b1;
                    wr_count++;
                    @(negedge clk);
                    aw_ready = 1'b0;
                end
            end
        end
    end

    // Write-data slave (can be frozen with w_hold)
    initial begin
        w_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (w_valid && !w_hold) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (w_valid && !w_hold) begin
                    w_q.push_back(w_data);
                    w_ready = 1'b1;
                    @(negedge clk);
                    w_ready = 1'b0;
                end
            end
        end
    end

    // Commit paired address/data beats into the memory model
    initial begin
        forever begin
            @(negedge clk);
            while (aw_q.size() > 0 && w_q.size() > 0)
                mem[aw_q.pop_front()] = w_q.pop_front();
        end
    end

    // Count every done pulse over the whole run
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_total++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_mem(input int v);
        for (int a = 0; a < 16; a++) mem[a] = 32'hDEAD_0000 | a;
        for (int k = 0; k < vecs[v].size; k++) mem[(vecs[v].base + k) % 16] = vecs[v].data[k];
    endtask

    task automatic check_mem(input int v, input string tag);
        int off;
        logic [31:0] expd;
        for (int a = 0; a < 16; a++) begin
            off  = (a - vecs[v].base + 16) % 16;
            expd = (off < vecs[v].size) ? vecs[v].expv[off] : (32'hDEAD_0000 | a);
            check($sformatf("%s mem[%0d]", tag, a), mem[a], expd);
        end
    endtask

    // Pulse start and wait (bounded) for done or error; optionally fire a
    // second start while the first sort is still running.
    task automatic run_sort(input int b, input int s, input bit d, input int inject_at,
                            output int done_cnt, output int lat, output bit busy0,
                            output bit err0, output bit err_seen);
        int cyc;
        @(negedge clk);
        base_addr  = b[AW-1:0];
        arr_size   = s[AW-1:0];
        descending = d;
        start      = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy0    = busy;
        err0     = error;
        done_cnt = 0;
        lat      = 0;
        err_seen = 1'b0;
        cyc      = 1;
        while (cyc < 6000) begin
            if (done) begin
                done_cnt++;
                if (lat == 0) lat = cyc;
            end
            if (error) begin
                err_seen = 1'b1;
                break;
            end
            if (lat != 0 && cyc >= lat + 4) break;
            if (cyc == inject_at) begin
                start = 1'b1; base_addr = 4'd9; arr_size = 4'd2; descending = ~d;
            end
            if (cyc == inject_at + 1) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " error"}, error, 0);
        check({tag, " ar_valid"}, ar_valid, 0);
        check({tag, " r_ready"}, r_ready, 0);
        check({tag, " aw_valid"}, aw_valid, 0);
        check({tag, " w_valid"}, w_valid, 0);
        check({tag, " ar_address"}, ar_address, 0);
        check({tag, " aw_address"}, aw_address, 0);
        check({tag, " w_data"}, w_data, 0);
    endtask

    initial begin
        int  done_cnt, lat, rd0, wr0, wr_at_err, done_at_err, n;
        bit  busy0, err0, err_seen;

        // base, size, desc, data, expected, reads, writes (-1 = not checked)
        vecs[0] = '{2, 5, 1'b0, pk8(5, 3, 9, 1, 7, 0, 0, 0), pk8(1, 3, 5, 7, 9, 0, 0, 0), 11, 8};
        vecs[1] = '{0, 4, 1'b1, pk8(-1, 4, -8, 0, 0, 0, 0, 0), pk8(4, 0, -1, -8, 0, 0, 0, 0), 8, 5};
        vecs[2] = '{5, 3, 1'b0, pk8(1, 2, 3, 0, 0, 0, 0, 0), pk8(1, 2, 3, 0, 0, 0, 0, 0), 4, 0};
        vecs[3] = '{14, 4, 1'b0, pk8(40, 10, 30, 20, 0, 0, 0, 0), pk8(10, 20, 30, 40, 0, 0, 0, 0), 9, 7};
        vecs[4] = '{0, 0, 1'b0, pk8(0, 0, 0, 0, 0, 0, 0, 0), pk8(0, 0, 0, 0, 0, 0, 0, 0), 0, 0};
        vecs[5] = '{3, 1, 1'b0, pk8(77, 0, 0, 0, 0, 0, 0, 0), pk8(77, 0, 0, 0, 0, 0, 0, 0), 0, 0};
        vecs[6] = '{9, 6, 1'b1, pk8(3, -2, 3, 7, -2, 0, 0, 0), pk8(7, 3, 3, 0, -2, -2, 0, 0), -1, -1};
        vecs[7] = '{0, 15, 1'b0, '0, '0, 119, 119};
        for (int k = 0; k < 15; k++) begin
            vecs[7].data[k] = 15 - k;
            vecs[7].expv[k] = k + 1;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset state", dut.r_state, IDLE);
        rst_n = 1'b1;

        // Table-driven sorts
        for (int v = 0; v < NV; v++) begin
            load_mem(v);
            rd0 = rd_count;
            wr0 = wr_count;
            run_sort(vecs[v].base, vecs[v].size, vecs[v].desc, -10, done_cnt, lat, busy0, err0, err_seen);
            $display("sort v%0d base=%0d size=%0d desc=%0d: done_pulses=%0d latency=%0d reads=%0d writes=%0d",
                     v, vecs[v].base, vecs[v].size, vecs[v].desc, done_cnt, lat, rd_count - rd0, wr_count - wr0);
            check($sformatf("v%0d done pulses", v), done_cnt, 1);
            check($sformatf("v%0d error", v), err_seen, 0);
            check($sformatf("v%0d busy after start", v), busy0, (vecs[v].size > 1));
            check($sformatf("v%0d busy at end", v), busy, 0);
            if (vecs[v].size <= 1)
                check($sformatf("v%0d short latency", v), (lat >= 1 && lat <= 2), 1);
            if (vecs[v].exp_rd >= 0)
                check($sformatf("v%0d reads", v), rd_count - rd0, vecs[v].exp_rd);
            if (vecs[v].exp_wr >= 0)
                check($sformatf("v%0d writes", v), wr_count - wr0, vecs[v].exp_wr);
            check_mem(v, $sformatf("v%0d", v));
        end

        // Error response on the third read
        load_mem(0);
        err_target = rd_count + 3;
        wr0 = wr_count;
        run_sort(2, 5, 1'b0, -10, done_cnt, lat, busy0, err0, err_seen);
        wr_at_err   = wr_count;
        done_at_err = done_total;
        $display("sort error-run: error_seen=%0d done_pulses=%0d writes=%0d", err_seen, done_cnt, wr_count - wr0);
        check("err seen", err_seen, 1);
        check("err no done", done_cnt, 0);
        check("err writes before", wr_count - wr0, 2);
        repeat (20) @(negedge clk);
        check("err sticky", error, 1);
        check("err busy", busy, 0);
        check("err no later writes", wr_count, wr_at_err);
        check("err no later done", done_total, done_at_err);
        check("err aw_valid", aw_valid, 0);
        err_target = -1;

        // A new start clears the error and sorts normally
        load_mem(0);
        run_sort(2, 5, 1'b0, -10, done_cnt, lat, busy0, err0, err_seen);
        $display("sort after-error: error_at_start=%0d done_pulses=%0d", err0, done_cnt);
        check("restart error cleared", err0, 0);
        check("restart done", done_cnt, 1);
        check_mem(0, "restart");

        // start while busy is ignored
        load_mem(0);
        rd0 = rd_count;
        wr0 = wr_count;
        run_sort(2, 5, 1'b0, 10, done_cnt, lat, busy0, err0, err_seen);
        $display("sort with mid-sort start: done_pulses=%0d reads=%0d writes=%0d",
                 done_cnt, rd_count - rd0, wr_count - wr0);
        check("midstart done", done_cnt, 1);
        check("midstart reads", rd_count - rd0, 11);
        check("midstart writes", wr_count - wr0, 8);
        check_mem(0, "midstart");

        // Reset while a shift write has its address accepted and data pending
        load_mem(0);
        w_hold = 1'b1;
        @(negedge clk);
        base_addr = 4'd2; arr_size = 4'd5; descending = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(w_valid && !aw_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rst-mid reached half write", (w_valid && !aw_valid), 1);
        rst_n = 1'b0;
        @(negedge clk);
        $display("reset mid-write after %0d cycles", n);
        check_idle_outputs("rst-mid");
        check("rst-mid state", dut.r_state, IDLE);
        rst_n  = 1'b1;
        w_hold = 1'b0;
        aw_q.delete();
        w_q.delete();
        @(negedge clk);
        load_mem(0);
        run_sort(2, 5, 1'b0, -10, done_cnt, lat, busy0, err0, err_seen);
        $display("sort after reset: done_pulses=%0d error=%0d", done_cnt, err_seen);
        check("post-reset done", done_cnt, 1);
        check("post-reset error", err_seen, 0);
        check_mem(0, "post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sort_engine.md
Name: sort_engine

Overview:
- Parameterised successor to the team's insertion-sort engine.
- Sorts an array of DATA_WDTH-bit words in external memory, in place, by insertion sort through a valid/ready AR/R/AW/W memory port.
- New over the previous generation: runtime base address, ascending/descending mode, signed/unsigned compare, no key write-back when the key is already in place, and a busy flag.
- Sits between the user/control plane and the memory fabric.

Parameters:
- ADDR_WDTH, 4: memory address width. Max array length is 2^ADDR_WDTH-1.
- DATA_WDTH, 32: element width.
- RESP_WDTH, 1: response width. Any nonzero response is an error.
- SIGNED_CMP, 0: 1 = compare elements as two's complement, 0 = unsigned.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- base_addr  in  ADDR_WDTH  array start address, sampled at start
- arr_size  in  ADDR_WDTH  element count, sampled at start
- descending  in  1  sort order, sampled at start
- start  in  1  begin sort (ignored unless idle, done or error)
- busy  out  1  sort in progress
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky error flag
- ar_valid  out  1  read-address valid
- ar_ready  in  1  read-address ready
- ar_address  out  ADDR_WDTH  read address
- r_valid  in  1  read-data valid
- r_ready  out  1  read-data ready
- r_resp  in  RESP_WDTH  read response
- r_data  in  DATA_WDTH  read data
- aw_valid  out  1  write-address valid
- aw_ready  in  1  write-address ready
- aw_address  out  ADDR_WDTH  write address
- w_valid  out  1  write-data valid
- w_ready  in  1  write-data ready
- w_data  out  DATA_WDTH  write data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low (rst_n low at a rising edge). It forces state IDLE and all outputs 0: busy, done, error, ar_valid, r_ready, aw_valid, w_valid, and all addresses and data. Reset mid-transaction abandons it immediately; no pending-handshake bookkeeping is kept.
- Start: latches base, size, order; clears error; sets i=1.
  - size <= 1: go to FINISH next cycle with no memory traffic.
- FSM states: IDLE, RD_KEY_A, RD_KEY_D, RD_CMP_A, RD_CMP_D, WR_SHIFT, WR_KEY, NEXT_I, FINISH, ERR.
  - RD_KEY_A: ar_valid=1, ar_address=base+i. On ar_ready go to RD_KEY_D.
  - RD_KEY_D: r_ready=1. On r_valid, key<=r_data, j<=i-1, go to RD_CMP_A.
  - RD_CMP_A / RD_CMP_D: same handshake at address base+j; cmp<=r_data.
  - After RD_CMP_D:
    - if out_of_order(key, cmp), go to WR_SHIFT;
    - else if j==i-1 (no shift happened), go to NEXT_I and skip the key write;
    - else go to WR_KEY.
  - out_of_order is: key<cmp when ascending, key>cmp when descending. It uses a signed compare when SIGNED_CMP=1. Equal elements never shift, so the sort is stable.
  - WR_SHIFT: write cmp to base+j+1. Then j<=j-1; if j was 0, go to WR_KEY, else go to RD_CMP_A.
  - WR_KEY: write key to base+j+1 (j is the post-decrement value, possibly -1), then go to NEXT_I.
  - NEXT_I: i<=i+1. If i+1<size, go to RD_KEY_A, else go to FINISH.
  - FINISH: done=1 for one cycle, busy=0, return to IDLE.
  - ERR: busy=0, error=1 held until the next start or reset.
- Index widths: j is held in ADDR_WDTH+1 bits, signed, so j=-1 is representable. Address arithmetic is base+index modulo 2^ADDR_WDTH; wrap-around past the top of memory is legal and must not be flagged.
- Read handshake rules:
  - ar_valid held with a stable address until ar_ready; it drops in the cycle after the handshake.
  - Only one read outstanding.
  - r_ready is asserted only in the *_D states.
  - r_valid outside *_D is ignored.
- Write handshake rules:
  - aw_valid and w_valid assert together. Each drops independently after its own handshake; address and data stay stable until it does.
  - The state advances only in the cycle where both handshakes have completed, whether simultaneous or in either order.
- Errors: r_resp != 0 on the R handshake goes to ERR with no further transactions; the data is discarded.
- start while busy is ignored.
- busy = 1 in all states except IDLE, FINISH and ERR.

Optional Feature:
- SORT_PERF_CNT_EN defined:
  - Adds output perf_count (16 bits), zeroed at start.
  - Increments once per completed read and once per completed write; saturates at 0xFFFF.
  - Holds its value in IDLE, FINISH and ERR.
- Undefined: no port, no logic.

Decomposition:
- Package sort_pkg holds:
  - the state enum sort_state_t;
  - the response constant RESP_OKAY=0;
  - the function out_of_order(key, cmp, desc, signed_cmp).
- One sub-module, sort_wr_handshake, tracks the independent AW/W acceptance and produces both_done. The read side and the FSM stay in sort_engine.

Test Plan:
- Memory with random 0-3 cycle ready/valid delays; base=2, size=5, data {5,3,9,1,7} ascending → memory {1,3,5,7,9} at addresses 2-6; done pulses once; error=0.
- Same data, descending=1, SIGNED_CMP=1, data {-1,4,-8,0} at base=0 → {4,0,-1,-8}; already-sorted input {1,2,3} ascending → zero writes issued.
- base=14, size=4, ADDR_WDTH=4 → addresses wrap 14,15,0,1; sorted correctly; no error.
- r_resp=1 on the third read → error=1, busy=0, no AW issued afterwards, done never pulses; next start clears error.
- size=0 and size=1 → done pulse within 2 cycles, no ar_valid or aw_valid; start asserted mid-sort is ignored.
- rst_n low during WR_SHIFT with aw accepted and w pending → next cycle all outputs 0 and state IDLE; a new sort then completes correctly.
